sort_loader: RTL and testbench

Front-end loader for the bubble-sort datapath. It accepts a frame of up to N words over a valid/ready stream and writes them to consecutive addresses of the sort memory. If the frame is short, it fills the remaining locations with all-ones pad words so the pads sort to the top. It then issues a one-cycle start pulse to the sort controller and holds off the next frame until the controller reports done.

---
 rtl/sort_loader_if.sv | 33 +++
 rtl/sort_loader.sv | 94 +++++++++
 tb/tb_sort_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_loader_if.sv
// rtl/sort_loader_if.sv - stream, memory-write and sort-control signals of the sort loader
interface sort_loader_if #(
    parameter int data_in_width = 16,
    parameter int addr_width    = 2
);
    logic                     in_valid;
    logic [data_in_width-1:0] in_data;
    logic                     in_last;
    logic                     in_ready;

    logic                     mem_wr_en;
    logic [addr_width-1:0]    mem_addr;
    logic [data_in_width-1:0] mem_wr_data;

    logic                     sort_start;
    logic                     sort_done;

    logic                     busy;
    logic [addr_width:0]      frame_len;
    logic                     len_err;

    modport slave (
        input  in_valid, in_data, in_last, sort_done,
        output in_ready, mem_wr_en, mem_addr, mem_wr_data,
               sort_start, busy, frame_len, len_err
    );

    modport master (
        output in_valid, in_data, in_last, sort_done,
        input  in_ready, mem_wr_en, mem_addr, mem_wr_data,
               sort_start, busy, frame_len, len_err
    );
endinterface

// File: rtl/sort_loader.sv
// rtl/sort_loader.sv - loads one frame into sort memory, pads short frames, kicks the sorter
module sort_loader #(
    parameter int data_in_width = 16,
    parameter int N             = 4,
    parameter int addr_width    = 2
) (
    input  logic          clk,
    input  logic          rst,
    sort_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        LOAD,
        PAD,
        KICK,
        START,
        WAIT
    } state_t;

    localparam logic [addr_width:0] LAST_PTR = (addr_width + 1)'(N - 1);
    localparam logic [addr_width:0] FULL_LEN = (addr_width + 1)'(N);

    state_t              state;
    logic [addr_width:0] ptr;
    logic                hs;

    // Ready is gated by rst so nothing is accepted in the reset cycle itself
    assign bus.in_ready = (state == LOAD) && !rst;
    assign hs           = bus.in_valid && bus.in_ready;
    assign bus.busy     = (state != LOAD) || (ptr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= LOAD;
            ptr             <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wr_data <= '0;
            bus.sort_start  <= 1'b0;
            bus.frame_len   <= '0;
            bus.len_err     <= 1'b0;
        end else begin
            bus.mem_wr_en  <= 1'b0;
            bus.sort_start <= 1'b0;
            case (state)
                LOAD: begin
                    if (hs) begin
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_addr    <= ptr[addr_width-1:0];
                        bus.mem_wr_data <= bus.in_data;
                        ptr             <= ptr + 1'b1;
                        if (ptr == LAST_PTR) begin
                            state         <= KICK;
                            bus.len_err   <= !bus.in_last;
                            bus.frame_len <= FULL_LEN;
                        end else begin
                            bus.len_err <= 1'b0;
                            if (bus.in_last) begin
                                state         <= PAD;
                                bus.frame_len <= ptr + 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    // All-ones pads sort above every real word
                    bus.mem_wr_en   <= 1'b1;
                    bus.mem_addr    <= ptr[addr_width-1:0];
                    bus.mem_wr_data <= '1;
                    ptr             <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state <= KICK;
                    end
                end
                KICK: begin
                    state <= START;
                end
                START: begin
                    bus.sort_start <= 1'b1;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (bus.sort_done) begin
                        state <= LOAD;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= LOAD;
                    ptr   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_loader.sv
// tb/tb_sort_loader.sv - randomized and directed frames checked against a frame-level model
module tb_sort_loader;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = 2;

    typedef logic [W-1:0] wq_t[$];
    typedef struct {
        int a;
        int d;
        int c;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sort_loader_if #(.data_in_width(W), .addr_width(AW)) bus ();
    sort_loader_if #(.data_in_width(W), .addr_width(1))  bus1 ();

    sort_loader #(.data_in_width(W), .N(N), .addr_width(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    sort_loader #(.data_in_width(W), .N(1), .addr_width(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int  checks = 0;
    int  passed = 0;
    int  fails  = 0;
    int  cyc    = 0;
    wr_t wr_q[$];
    int  start_q[$];
    int  busy_low   = 0;
    bit  track_busy = 1'b0;
    int  last_len   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1)
            wr_q.push_back('{int'(bus.mem_addr), int'(bus.mem_wr_data), cyc});
        if (bus.sort_start === 1'b1)
            start_q.push_back(cyc);
        if (track_busy && bus.busy !== 1'b1)
            busy_low++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit last);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("send ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Model: real words at 0..L-1, pads to N-1, start two cycles after the final write
    task automatic run_frame(input string tag, input wq_t w, input bit last, input int max_gap);
        wq_t exp_d;
        int  t;
        wr_q.delete();
        start_q.delete();
        busy_low = 0;
        for (int i = 0; i < w.size(); i++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            send(w[i], last && (i == w.size() - 1));
            if (i == 0) begin
                track_busy = 1'b1;
                chk({tag, " len_err cleared"}, bus.len_err, 0);
                if (!(last && w.size() == 1))
                    chk({tag, " frame_len held"}, bus.frame_len, last_len);
            end
        end
        exp_d = w;
        while (exp_d.size() < N) exp_d.push_back({W{1'b1}});
        t = 0;
        while (start_q.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        track_busy = 1'b0;
        chk({tag, " start count"}, start_q.size(), 1);
        chk({tag, " write count"}, wr_q.size(), N);
        for (int i = 0; i < wr_q.size() && i < N; i++) begin
            chk({tag, " addr"}, wr_q[i].a, i);
            chk({tag, " data"}, wr_q[i].d, exp_d[i]);
            if (i > 0 && (max_gap == 0 || i >= w.size()))
                chk({tag, " write spacing"}, wr_q[i].c - wr_q[i-1].c, 1);
        end
        if (wr_q.size() == N && start_q.size() > 0)
            chk({tag, " start latency"}, start_q[0] - wr_q[N-1].c, 2);
        chk({tag, " busy throughout"}, busy_low, 0);
        chk({tag, " frame_len"}, bus.frame_len, w.size());
        chk({tag, " len_err"}, bus.len_err, !last);
        chk({tag, " ready in wait"}, bus.in_ready, 0);
        last_len = w.size();
    endtask

    task automatic release_frame(input string tag, input bit hold_valid);
        wr_q.delete();
        if (hold_valid) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'($urandom);
            bus.in_last  = 1'b0;
            repeat (4) @(negedge clk);
            #1 chk({tag, " ready held low"}, bus.in_ready, 0);
        end
        bus.sort_done = 1'b1;
        @(negedge clk);
        bus.sort_done = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        chk({tag, " ready after done"}, bus.in_ready, 1);
        chk({tag, " idle after done"}, bus.busy, 0);
        if (hold_valid) chk({tag, " no write in wait"}, wr_q.size(), 0);
    endtask

    initial begin
        wq_t w;
        int  len;
        bit  lst;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.sort_done  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.in_last   = 1'b0;
        bus1.sort_done = 1'b0;

        repeat (2) @(negedge clk);
        #1 chk("ready during rst", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst mem_wr_en", bus.mem_wr_en, 0);
        chk("rst mem_addr", bus.mem_addr, 0);
        chk("rst mem_wr_data", bus.mem_wr_data, 0);
        chk("rst sort_start", bus.sort_start, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst frame_len", bus.frame_len, 0);
        chk("rst len_err", bus.len_err, 0);
        @(negedge clk);

        w = '{16'd9, 16'd3, 16'd7, 16'd1};
        run_frame("full", w, 1'b1, 0);
        release_frame("full", 1'b0);

        w = '{16'd5, 16'd2};
        run_frame("short", w, 1'b1, 0);
        release_frame("short", 1'b0);

        w = '{16'd10, 16'd20, 16'd30, 16'd40};
        run_frame("nolast", w, 1'b0, 0);
        release_frame("nolast", 1'b0);

        w = '{16'hA1, 16'hB2, 16'hC3, 16'hD4};
        run_frame("gaps", w, 1'b1, 1);
        release_frame("gaps", 1'b1);

        wr_q.delete();
        start_q.delete();
        send(16'd11, 1'b0);
        send(16'd22, 1'b0);
        rst = 1'b1;
        #1 chk("midrst ready low", bus.in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst ready", bus.in_ready, 1);
        chk("midrst busy", bus.busy, 0);
        chk("midrst frame_len", bus.frame_len, 0);
        wr_q.delete();
        start_q.delete();
        repeat (6) @(negedge clk);
        chk("midrst no writes", wr_q.size(), 0);
        chk("midrst no start", start_q.size(), 0);
        last_len = 0;
        w = '{16'd4, 16'd4, 16'd4, 16'd4};
        run_frame("after rst", w, 1'b1, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("wait rst ready", bus.in_ready, 1);
        last_len = 0;
        @(negedge clk);

        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(N, 1);
            lst = (len < N) ? 1'b1 : 1'($urandom_range(1, 0));
            w.delete();
            for (int i = 0; i < len; i++) w.push_back(W'($urandom));
            run_frame($sformatf("rand%0d", f), w, lst, $urandom_range(2, 0));
            release_frame($sformatf("rand%0d", f), 1'($urandom_range(1, 0)));
        end

        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'h1234;
        bus1.in_last  = 1'b1;
        #1 chk("n1 ready", bus1.in_ready, 1);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.in_last  = 1'b0;
        chk("n1 write", bus1.mem_wr_en, 1);
        chk("n1 addr", bus1.mem_addr, 0);
        chk("n1 data", bus1.mem_wr_data, 16'h1234);
        @(negedge clk);
        chk("n1 no pad", bus1.mem_wr_en, 0);
        chk("n1 early start", bus1.sort_start, 0);
        @(negedge clk);
        chk("n1 start", bus1.sort_start, 1);
        chk("n1 frame_len", bus1.frame_len, 1);
        chk("n1 len_err", bus1.len_err, 0);
        @(negedge clk);
        chk("n1 single start", bus1.sort_start, 0);
        bus1.sort_done = 1'b1;
        @(negedge clk);
        bus1.sort_done = 1'b0;
        #1 chk("n1 ready after done", bus1.in_ready, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
